// File: rtl/mul_pipeline.sv
// Fixed-latency RV32M multiplier pipe (MUL/MULH/MULHSU/MULHU) with global freeze, kill and rd lookup.
// Optional MUL_PIPE_PERF_EN macro adds the perf_issued / perf_stall counters.
module mul_pipeline #(
  parameter int XLEN   = 32,
  parameter int STAGES = 5,
  parameter int RD_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [RD_W-1:0] in_rd,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  input  logic [RD_W-1:0] chk_rd,
  output logic            chk_hit,
  output logic            busy
`ifdef MUL_PIPE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  localparam int PW = 2*XLEN;
  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULH  = 2'd1;
  localparam logic [1:0] OP_MULHU = 2'd3;

  logic [STAGES-1:0] v;
  logic [RD_W-1:0]   rd_q  [STAGES];
  logic [1:0]        op_q  [STAGES];
  logic signed [XLEN:0] a_q, b_q;
  logic signed [XLEN:0] a_ext, b_ext;
  logic [PW-1:0]     prod_q [1:STAGES-1];
  logic signed [PW-1:0] a_w, b_w, prod_next;

  logic hold;
  logic accept;

  assign hold     = v[STAGES-1] & ~out_ready;
  assign in_ready = ~hold;
  assign accept   = in_valid & ~hold & ~kill;

  always_comb begin
    a_ext = (in_op == OP_MULHU) ? {1'b0, in_rs1} : {in_rs1[XLEN-1], in_rs1};
    b_ext = (in_op == OP_MUL || in_op == OP_MULH) ? {in_rs2[XLEN-1], in_rs2} : {1'b0, in_rs2};
  end

  // Only the low 2*XLEN bits of the (2*XLEN+2)-bit signed product ever reach a result,
  // so the operands are sign-extended just far enough to produce those bits exactly.
  assign a_w       = {{(PW-XLEN-1){a_q[XLEN]}}, a_q};
  assign b_w       = {{(PW-XLEN-1){b_q[XLEN]}}, b_q};
  assign prod_next = a_w * b_w;

  // Kill wins over hold: the whole pipe empties at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (kill) begin
      v <= '0;
    end else if (!hold) begin
      v <= {v[STAGES-2:0], accept};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        rd_q[i] <= '0;
        op_q[i] <= '0;
      end
      a_q <= '0;
      b_q <= '0;
    end else if (!hold) begin
      rd_q[0] <= in_rd;
      op_q[0] <= in_op;
      a_q     <= a_ext;
      b_q     <= b_ext;
      for (int i = 1; i < STAGES; i++) begin
        rd_q[i] <= rd_q[i-1];
        op_q[i] <= op_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < STAGES; i++) begin
        prod_q[i] <= '0;
      end
    end else if (!hold) begin
      prod_q[1] <= prod_next;
      for (int i = 2; i < STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign out_valid  = v[STAGES-1] & ~kill;
  assign out_rd     = rd_q[STAGES-1];
  assign out_result = (op_q[STAGES-1] == OP_MUL) ? prod_q[STAGES-1][XLEN-1:0]
                                                 : prod_q[STAGES-1][PW-1:XLEN];
  assign busy       = |v;

  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (v[i] && (rd_q[i] == chk_rd)) chk_hit = 1'b1;
    end
    if (chk_rd == '0) chk_hit = 1'b0;
  end

`ifdef MUL_PIPE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept) perf_issued <= perf_issued + 32'd1;
      if (hold)   perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_pipeline.sv
// Scoreboard bench for mul_pipeline: queue-based in-flight model, 64-bit arithmetic reference.
module tb_mul_pipeline;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [4:0]  chk_rd = 5'd3;
  logic        chk_hit;
  logic        busy;
`ifdef MUL_PIPE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  mul_pipeline dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .chk_rd(chk_rd),
    .chk_hit(chk_hit), .busy(busy)
`ifdef MUL_PIPE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned m_issued = 0;
  int unsigned m_stall = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_res;
  logic [4:0]  prev_rd;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: begin up = ua * ub; return up[31:0]; end
      2'd1: begin p = sa * sb; return p[63:32]; end
      2'd2: begin p = sa * longint'(ub); return p[63:32]; end
      default: begin up = ua * ub; return up[63:32]; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor / scoreboard: mid-cycle sampling, inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_hold = 0;
      m_issued  = 0;
      m_stall   = 0;
    end else begin
      bit exp_hit;
      exp_hit = 0;
      if (chk_rd != 5'd0)
        foreach (q[i]) if (q[i].rd == chk_rd) exp_hit = 1;
      chk("busy", busy, q.size() != 0);
      chk("chk_hit", chk_hit, exp_hit);
      if (!in_ready) m_stall++;
      if (kill) begin
        chk("kill_gate", out_valid, 0);
        q.delete();
        prev_hold = 0;
      end else begin
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_result", out_result, prev_res);
          chk("hold_rd", out_rd, prev_rd);
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("spurious_out", out_valid, 0);
          end else begin
            chk("result", out_result, q[0].res);
            chk("rd", out_rd, q[0].rd);
            if (out_ready) void'(q.pop_front());
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_res  = out_result;
        prev_rd   = out_rd;
        if (in_valid && in_ready) begin
          q.push_back('{res: model(in_op, in_rs1, in_rs2), rd: in_rd});
          m_issued++;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready && !kill) begin ok = 1; break; end
    end
    if (!ok) tmo("issue");
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    kill = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    if (q.size() != 0) tmo("drain");
    chk("drained_busy", busy, 0);
  endtask

  task automatic wait_out_valid(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) tmo(name);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chk_hit", chk_hit, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_rd", out_rd, 0);
`ifdef MUL_PIPE_PERF_EN
    chk("rst_perf_issued", perf_issued, 0);
    chk("rst_perf_stall", perf_stall, 0);
`endif
    @(posedge clk); #1;

    // Latency of a single MUL
    issue(2'd0, 32'd7, 32'd6, 5'd3);
    idle();
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    chk("mul_latency", lat, 5);
    chk("mul_7x6", out_result, 32'd42);
    chk("mul_7x6_rd", out_rd, 5'd3);
    @(posedge clk); #1;
    drain();

    // Directed corner products, back to back
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    issue(2'd2, 32'hFFFF_FFFF, 32'd2, 5'd5);
    issue(2'd0, 32'h8000_0000, 32'd2, 5'd6);
    issue(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd7);
    idle();
    drain();

    // rd lookup
    issue(2'd0, 32'd3, 32'd5, 5'd9);
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_rd = 5'd9;
    #1 chk("chk_hit_rd9", chk_hit, 1);
    chk_rd = 5'd10;
    #1 chk("chk_hit_rd10", chk_hit, 0);
    drain();
    chk_rd = 5'd0;
    issue(2'd0, 32'd2, 32'd2, 5'd0);
    idle();
    #1;
    chk("chk_hit_rd0", chk_hit, 0);
    chk("busy_rd0", busy, 1);
    drain();

    // Back pressure: 4 ops, hold 3 cycles once the first is valid
    issue(2'd0, 32'd11, 32'd12, 5'd11);
    issue(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd12);
    issue(2'd2, 32'h8765_4321, 32'hCAFE_F00D, 5'd13);
    issue(2'd3, 32'hFFFF_0000, 32'h0001_FFFF, 5'd14);
    idle();
    out_ready = 1'b0;
    wait_out_valid("hold_first_valid");
    chk("hold_in_ready0", in_ready, 0);
    in_valid = 1'b1; in_op = 2'd0; in_rs1 = 32'd100; in_rs2 = 32'd3; in_rd = 5'd15;
    repeat (2) begin
      @(posedge clk); #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    issue(2'd0, 32'd100, 32'd3, 5'd15);
    idle();
    drain();

    // Kill with three ops in flight
    issue(2'd0, 32'd21, 32'd2, 5'd21);
    issue(2'd0, 32'd22, 32'd2, 5'd22);
    issue(2'd0, 32'd23, 32'd2, 5'd23);
    idle();
    wait_out_valid("kill_first_valid");
    kill = 1'b1;
    in_valid = 1'b1; in_op = 2'd0; in_rs1 = 32'd99; in_rs2 = 32'd99; in_rd = 5'd24;
    #1 chk("kill_out_valid", out_valid, 0);
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy_next", busy, 0);
    chk("kill_out_valid_next", out_valid, 0);
    issue(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd25);
    idle();
    drain();

    // Asynchronous reset mid-flight
    issue(2'd1, 32'd31, 32'hFFFF_FFF0, 5'd26);
    issue(2'd0, 32'd32, 32'd4, 5'd27);
    idle();
    wait_out_valid("rst_first_valid");
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_result", out_result, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef MUL_PIPE_PERF_EN
    chk("rst_perf_issued2", perf_issued, 0);
    chk("rst_perf_stall2", perf_stall, 0);
`endif
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_rs1    = rnd_operand();
      in_rs2    = rnd_operand();
      in_rd     = 5'($urandom_range(0, 7));
      chk_rd    = 5'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      kill      = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    drain();
`ifdef MUL_PIPE_PERF_EN
    chk("perf_issued", perf_issued, m_issued);
    chk("perf_stall", perf_stall, m_stall);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "global timeout");
  end
endmodule
